// File: rtl/line_cmd_pkg.sv
// Shared constants, entry layout and dispatcher states for the line command queue.
package line_cmd_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 24;
  localparam int ENTRY_W = 64;

  localparam int Y1_LSB  = 0;
  localparam int X1_LSB  = 10;
  localparam int Y0_LSB  = 20;
  localparam int X0_LSB  = 30;
  localparam int RGB_LSB = 40;

  localparam logic [2:0] OFF_COLOR = 3'd0;
  localparam logic [2:0] OFF_X0    = 3'd1;
  localparam logic [2:0] OFF_Y0    = 3'd2;
  localparam logic [2:0] OFF_X1    = 3'd3;
  localparam logic [2:0] OFF_Y1    = 3'd4;
  localparam logic [2:0] OFF_GO    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TRIG,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } disp_state_e;

  // Field order gives {rgb, x0, y0, x1, y1} at the LSB positions above.
  typedef struct packed {
    logic [RGB_W-1:0]   rgb;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
  } line_cmd_t;

endpackage

// File: rtl/line_cmd_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module line_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == FULL_CNT);
  assign empty_o = (wptr_q == rptr_q);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= din_i;
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/line_cmd_queue.sv
// CPU shadow registers, command FIFO and dispatcher feeding the line engine.
// Define LINE_CMD_STATS_EN to build the lines_done completion counter.
module line_cmd_queue
  import line_cmd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_wr_en,
  input  logic [2:0]                cpu_addr,
  input  logic [31:0]               cpu_wdata,
  output logic                      q_full,
  output logic [$clog2(DEPTH):0]    q_count,
  output logic                      overflow,
  output logic                      idle,
  input  logic                      LE_ready,
  output logic [COORD_W-1:0]        LE_point,
  output logic [31:0]               LE_color,
  output logic                      LE_x0_valid,
  output logic                      LE_y0_valid,
  output logic                      LE_x1_valid,
  output logic                      LE_y1_valid,
  output logic                      LE_color_valid,
  output logic                      LE_trigger,
  output logic [15:0]               lines_done
);

  line_cmd_t   shadow_q, head;
  logic        overflow_q, go, q_empty, pop;
  logic        unused_wdata;
  disp_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;

  assign go           = cpu_wr_en && (cpu_addr == OFF_GO);
  assign unused_wdata = ^cpu_wdata[31:RGB_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (cpu_wr_en) begin
        case (cpu_addr)
          OFF_COLOR: shadow_q.rgb <= cpu_wdata[RGB_W-1:0];
          OFF_X0:    shadow_q.x0  <= cpu_wdata[COORD_W-1:0];
          OFF_Y0:    shadow_q.y0  <= cpu_wdata[COORD_W-1:0];
          OFF_X1:    shadow_q.x1  <= cpu_wdata[COORD_W-1:0];
          OFF_Y1:    shadow_q.y1  <= cpu_wdata[COORD_W-1:0];
          default:   ;
        endcase
      end
      if (go && q_full) overflow_q <= 1'b1;
    end
  end

  line_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (go),
    .din_i   (shadow_q),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign overflow = overflow_q;
  assign idle     = q_empty && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    pop            = 1'b0;
    LE_point       = '0;
    LE_color       = '0;
    LE_x0_valid    = 1'b0;
    LE_y0_valid    = 1'b0;
    LE_x1_valid    = 1'b0;
    LE_y1_valid    = 1'b0;
    LE_color_valid = 1'b0;
    LE_trigger     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!q_empty && LE_ready) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        LE_color = {8'h00, head.rgb};
        unique case (idx_q)
          3'd0: begin LE_x0_valid = 1'b1; LE_point = head.x0; end
          3'd1: begin LE_y0_valid = 1'b1; LE_point = head.y0; end
          3'd2: begin LE_x1_valid = 1'b1; LE_point = head.x1; end
          3'd3: begin LE_y1_valid = 1'b1; LE_point = head.y1; end
          default: LE_color_valid = 1'b1;
        endcase
        if (idx_q == 3'd4) state_d = S_TRIG;
        else idx_d = idx_q + 3'd1;
      end
      S_TRIG: begin
        LE_trigger = 1'b1;
        pop        = 1'b1;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (!LE_ready) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (LE_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef LINE_CMD_STATS_EN
  logic [15:0] lines_q;
  logic        line_done;

  assign line_done = (state_q == S_WAIT_DONE) && LE_ready;

  always_ff @(posedge clk) begin
    if (rst) lines_q <= '0;
    else if (line_done) lines_q <= lines_q + 16'd1;
  end

  assign lines_done = lines_q;
`else
  assign lines_done = '0;
`endif

endmodule

// File: tb/tb_line_cmd_queue.sv
// Randomized bench for line_cmd_queue with a queue-based command model
// and a behavioural line engine that drops ready after each trigger.
module tb_line_cmd_queue;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [23:0] rgb;
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [9:0]  x1;
    logic [9:0]  y1;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_wr_en = 1'b0;
  logic [2:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        LE_ready = 1'b1;
  logic        q_full, overflow, idle;
  logic [3:0]  q_count;
  logic [9:0]  LE_point;
  logic [31:0] LE_color;
  logic        LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid;
  logic        LE_color_valid, LE_trigger;
  logic [15:0] lines_done;

  int checks = 0;
  int errors = 0;

  cmd_t exp_q[$];
  cmd_t obs_q[$];
  int   trig_qc[$];
  cmd_t sh = '0;
  cmd_t cur = '0;

  int cyc = 0;
  int go_cyc = 0, x0_cyc = 0, color_cyc = 0, trig_cyc = 0, trig_cnt = 0;
  logic [31:0] last_color = '0;
  int excl_viol = 0, ready_viol = 0, ord_viol = 0, col_viol = 0;
  int prev_k = 5;
  int busy_cnt = 0, busy_len = 3;
  bit hold_low = 1'b0;

  line_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_wr_en      (cpu_wr_en),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .q_full         (q_full),
    .q_count        (q_count),
    .overflow       (overflow),
    .idle           (idle),
    .LE_ready       (LE_ready),
    .LE_point       (LE_point),
    .LE_color       (LE_color),
    .LE_x0_valid    (LE_x0_valid),
    .LE_y0_valid    (LE_y0_valid),
    .LE_x1_valid    (LE_x1_valid),
    .LE_y1_valid    (LE_y1_valid),
    .LE_color_valid (LE_color_valid),
    .LE_trigger     (LE_trigger),
    .lines_done     (lines_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor first, then the engine model updates ready for the next edge.
  always @(negedge clk) begin : mon
    int ns, k;
    if (idle) prev_k = 5;
    ns = int'(LE_x0_valid) + int'(LE_y0_valid) + int'(LE_x1_valid)
       + int'(LE_y1_valid) + int'(LE_color_valid) + int'(LE_trigger);
    k = -1;
    if (ns > 1) excl_viol++;
    if (ns != 0 && !LE_ready) ready_viol++;
    if (LE_x0_valid) begin cur.x0 = LE_point; k = 0; x0_cyc = cyc; end
    if (LE_y0_valid) begin cur.y0 = LE_point; k = 1; end
    if (LE_x1_valid) begin cur.x1 = LE_point; k = 2; end
    if (LE_y1_valid) begin cur.y1 = LE_point; k = 3; end
    if (LE_color_valid) begin
      cur.rgb = LE_color[23:0];
      last_color = LE_color;
      color_cyc = cyc;
      if (LE_color[31:24] != 8'h00) col_viol++;
      k = 4;
    end
    if (LE_trigger) begin
      obs_q.push_back(cur);
      trig_qc.push_back(int'(q_count));
      trig_cnt++;
      trig_cyc = cyc;
      k = 5;
    end
    if (ns == 1) begin
      if (k != (prev_k + 1) % 6) ord_viol++;
      prev_k = k;
    end
    if (LE_trigger) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    LE_ready = !hold_low && (busy_cnt == 0);
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_wr_en = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  task automatic wr_end();
    @(negedge clk);
    cpu_wr_en = 1'b0;
  endtask

  task automatic go();
    wr(3'd5, $urandom);
    go_cyc = cyc + 1;
    if (exp_q.size() - obs_q.size() < DEPTH) exp_q.push_back(sh);
    wr_end();
  endtask

  task automatic post_vals(input cmd_t c);
    logic [31:0] r;
    r = $urandom; wr(3'd0, {r[31:24], c.rgb}); sh.rgb = c.rgb;
    r = $urandom; wr(3'd1, {r[31:10], c.x0});  sh.x0 = c.x0;
    r = $urandom; wr(3'd2, {r[31:10], c.y0});  sh.y0 = c.y0;
    r = $urandom; wr(3'd3, {r[31:10], c.x1});  sh.x1 = c.x1;
    r = $urandom; wr(3'd4, {r[31:10], c.y1});  sh.y1 = c.y1;
    r = $urandom; wr(r[0] ? 3'd7 : 3'd6, r);
    go();
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.rgb = 24'($urandom);
    c.x0  = 10'($urandom);
    c.y0  = 10'($urandom);
    c.x1  = 10'($urandom);
    c.y1  = 10'($urandom);
    return c;
  endfunction

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (idle) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid,
         LE_color_valid, LE_trigger} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes got nonzero want 0");
    end
    checks++;
    if (LE_point !== 10'd0 || LE_color !== 32'd0) begin
      errors++; $display("FAIL reset_buses got %h/%h want 0/0", LE_point, LE_color);
    end
    checks++;
    if (q_count !== 4'd0 || q_full !== 1'b0) begin
      errors++; $display("FAIL reset_queue got cnt %0d full %b want 0 0", q_count, q_full);
    end
    checks++;
    if (overflow !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL reset_flags got ovf %b idle %b want 0 1", overflow, idle);
    end
    checks++;
    if (lines_done !== 16'd0) begin
      errors++; $display("FAIL reset_lines got %0d want 0", lines_done);
    end
  endtask

  task automatic test_single();
    cmd_t c;
    bit ok;
    exp_q.delete(); obs_q.delete();
    busy_len = 3;
    c = '{rgb: 24'h00FF00, x0: 10'd0, y0: 10'd0, x1: 10'd300, y1: 10'd200};
    post_vals(c);
    wait_idle(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout got busy want idle"); end
    checks++;
    if (x0_cyc !== go_cyc + 1) begin
      errors++; $display("FAIL single_x0_edge got %0d want %0d", x0_cyc, go_cyc + 1);
    end
    checks++;
    if (color_cyc !== go_cyc + 5) begin
      errors++; $display("FAIL single_color_edge got %0d want %0d", color_cyc, go_cyc + 5);
    end
    checks++;
    if (trig_cyc !== go_cyc + 6) begin
      errors++; $display("FAIL single_trig_edge got %0d want %0d", trig_cyc, go_cyc + 6);
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== c) begin
      errors++; $display("FAIL single_cmd got %0d entries want 1 of %h", obs_q.size(), c);
    end
    checks++;
    if (last_color !== 32'h0000FF00) begin
      errors++; $display("FAIL single_color got %h want 0000ff00", last_color);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    exp_q.delete(); obs_q.delete(); trig_qc.delete();
    busy_len = 50;
    hold_low = 1'b1;
    repeat (3) post_vals(rand_cmd());
    checks++;
    if (q_count !== 4'd3) begin
      errors++; $display("FAIL b2b_count got %0d want 3", q_count);
    end
    hold_low = 1'b0;
    wait_idle(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout got busy want idle"); end
    checks++;
    if (trig_qc.size() != 3) begin
      errors++; $display("FAIL b2b_triggers got %0d want 3", trig_qc.size());
    end
    for (int i = 0; i < trig_qc.size() && i < 3; i++) begin
      checks++;
      if (trig_qc[i] != 3 - i) begin
        errors++; $display("FAIL b2b_step%0d got %0d want %0d", i, trig_qc[i], 3 - i);
      end
    end
    checks++;
    if (q_count !== 4'd0) begin
      errors++; $display("FAIL b2b_final_count got %0d want 0", q_count);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_entry%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fill_overflow();
    bit ok;
    cmd_t c9;
    exp_q.delete(); obs_q.delete();
    busy_len = 2;
    hold_low = 1'b1;
    repeat (DEPTH) post_vals(rand_cmd());
    checks++;
    if (q_full !== 1'b1 || q_count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_state got full %b cnt %0d ovf %b want 1 8 0", q_full, q_count, overflow);
    end
    c9 = rand_cmd();
    post_vals(c9);
    checks++;
    if (overflow !== 1'b1 || q_count !== 4'd8 || q_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_ovf got ovf %b cnt %0d full %b want 1 8 1", overflow, q_count, q_full);
    end
    hold_low = 1'b0;
    wait_idle(2000, ok);
    checks++;
    if (!ok || obs_q.size() != DEPTH) begin
      errors++; $display("FAIL fill_drain got %0d lines want %0d", obs_q.size(), DEPTH);
    end
    go();
    wait_idle(200, ok);
    checks++;
    if (!ok || overflow !== 1'b1) begin
      errors++; $display("FAIL fill_sticky got ovf %b want 1", overflow);
    end
    checks++;
    if (exp_q.size() != DEPTH + 1 || exp_q[DEPTH] !== c9) begin
      errors++; $display("FAIL fill_model got %0d entries want %0d", exp_q.size(), DEPTH + 1);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL fill_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL fill_entry%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_simul_push_pop();
    bit ok, found;
    exp_q.delete(); obs_q.delete();
    busy_len = 2;
    hold_low = 1'b1;
    repeat (4) post_vals(rand_cmd());
    checks++;
    if (q_count !== 4'd4) begin
      errors++; $display("FAIL simul_pre got %0d want 4", q_count);
    end
    hold_low = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (LE_trigger) begin found = 1'b1; break; end
    end
    cpu_wr_en = found;
    cpu_addr  = 3'd5;
    cpu_wdata = $urandom;
    if (found) exp_q.push_back(sh);
    @(negedge clk);
    cpu_wr_en = 1'b0;
    checks++;
    if (!found || q_count !== 4'd4) begin
      errors++; $display("FAIL simul_count got %0d want 4", q_count);
    end
    wait_idle(500, ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL simul_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL simul_entry%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int t0;
    hold_low = 1'b1;
    post_vals(rand_cmd());
    hold_low = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (LE_x1_valid) begin found = 1'b1; break; end
    end
    t0 = trig_cnt;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!found || {LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid,
                   LE_color_valid, LE_trigger} !== 6'b0) begin
      errors++; $display("FAIL rstmid_strobes got nonzero want 0");
    end
    checks++;
    if (q_count !== 4'd0 || idle !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state got cnt %0d idle %b ovf %b want 0 1 0", q_count, idle, overflow);
    end
    rst = 1'b0;
    exp_q.delete(); obs_q.delete();
    sh = '0;
    repeat (30) @(negedge clk);
    checks++;
    if (trig_cnt != t0 || idle !== 1'b1 || lines_done !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_replay got trig %0d idle %b lines %0d want %0d 1 0",
               trig_cnt, idle, lines_done, t0);
    end
  endtask

  task automatic test_lines_done();
    bit ok;
    int want;
    busy_len = 4;
    hold_low = 1'b1;
    go();
    repeat (4) post_vals(rand_cmd());
    hold_low = 1'b0;
    wait_idle(1000, ok);
`ifdef LINE_CMD_STATS_EN
    want = 5;
`else
    want = 0;
`endif
    checks++;
    if (!ok || lines_done !== 16'(want)) begin
      errors++; $display("FAIL lines_done got %0d want %0d", lines_done, want);
    end
    checks++;
    if (obs_q.size() != 5 || exp_q[0] !== cmd_t'(0)) begin
      errors++; $display("FAIL lines_len got %0d want 5", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL lines_entry%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (excl_viol != 0) begin
      errors++; $display("FAIL inv_exclusive got %0d want 0", excl_viol);
    end
    checks++;
    if (ready_viol != 0) begin
      errors++; $display("FAIL inv_ready got %0d want 0", ready_viol);
    end
    checks++;
    if (ord_viol != 0) begin
      errors++; $display("FAIL inv_order got %0d want 0", ord_viol);
    end
    checks++;
    if (col_viol != 0) begin
      errors++; $display("FAIL inv_color_msb got %0d want 0", col_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_overflow();
    test_simul_push_pop();
    test_reset_mid();
    test_lines_done();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_cmd_queue.md
# line_cmd_queue

Upstream command stage for the line engine. Captures CPU memory-mapped stores of line endpoints and colour into shadow registers, then snapshots them into a small FIFO on a GO write. A dispatcher replays each queued command into the line engine's point/colour/valid/trigger inputs, one line at a time, gated by the engine's ready flag. The CPU can post several lines back-to-back without polling the engine.

## Interface
- DEPTH, 8, queue entries; power of two, minimum 2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_wr_en  in  1  CPU store strobe, one cycle per store
- cpu_addr  in  3  register offset: 0 COLOR, 1 X0, 2 Y0, 3 X1, 4 Y1, 5 GO; 6–7 ignored
- cpu_wdata  in  32  store data; COLOR uses [23:0], coordinates use [9:0], GO ignores data
- q_full  out  1  queue holds DEPTH entries
- q_count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; a GO was dropped while full
- idle  out  1  queue empty and dispatcher in IDLE
- LE_ready  in  1  line engine can accept a command
- LE_point  out  10  coordinate bus
- LE_color  out  32  {8'h00, rgb[23:0]}
- LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_color_valid  out  1 each  load strobes
- LE_trigger  out  1  start-draw pulse
- lines_done  out  16  completed-line counter (only with LINE_CMD_STATS_EN)

## Operation
- Shadow registers update on any store to offsets 0–4, at any time, including during dispatch.
- GO with the queue not full pushes a 64-bit entry {rgb[23:0], x0, y0, x1, y1}.
- GO with the queue full:
  - The entry is dropped and overflow is set.
  - Shadow registers are untouched.
  - overflow clears only on rst.
- Dispatcher FSM:
  - IDLE: if q_count != 0 and LE_ready, go to LOAD with idx = 0.
  - LOAD: five cycles, idx 0..4. Each cycle drives exactly one strobe in the order X0, Y0, X1, Y1, COLOR. LE_point carries the matching field of the FIFO head; LE_color carries the head colour throughout LOAD. After idx 4, go to TRIG.
  - TRIG: LE_trigger high for one cycle, and the FIFO pops on this edge. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for LE_ready = 0, then go to WAIT_DONE.
  - WAIT_DONE: wait for LE_ready = 1, then go to IDLE. lines_done increments on this transition and wraps at 16'hFFFF → 0.
- Simultaneous push and pop in one cycle: q_count is unchanged and both operations take effect.
- Reads from the FIFO head are combinational; the head stays stable from IDLE exit until the pop.

## Timing
- Reset values:
  - All LE_* outputs 0; LE_point 0; LE_color 0.
  - q_count 0; q_full 0; overflow 0; idle 1; lines_done 0.
  - Queue and shadow registers cleared; FSM in IDLE.
- GO accepted at edge N with an empty queue, IDLE, and LE_ready high:
  - LE_x0_valid is high in the cycle after edge N+1.
  - LE_color_valid is high after edge N+5.
  - LE_trigger is high after edge N+6.
- A push becomes visible to q_count and q_full after the same edge.
- rst mid-dispatch:
  - The FSM returns to IDLE and all strobes drop the next cycle.
  - The queued command is discarded, not replayed.
- Strobes are mutually exclusive; LE_trigger is never coincident with a strobe.

## Configuration
- LINE_CMD_STATS_EN defined: the lines_done counter is present and behaves as described above.
- LINE_CMD_STATS_EN undefined: lines_done is tied to 0 and no counter flops are built.

## Structure
- Package line_cmd_pkg holds:
  - Register offset constants (OFF_COLOR … OFF_GO).
  - Dispatcher state enum.
  - Entry field widths and bit positions (COORD_W = 10, RGB_W = 24, ENTRY_W = 64).
- Sub-module line_cmd_fifo: synchronous FIFO with parameters DEPTH and WIDTH, push/pop, head data, count, full, empty. Pointer wrap uses the extra MSB.

## Test plan
- Program colour 0x00FF00, points (0,0)-(300,200), GO, LE_ready held 1. Expect, in order: X0 = 0, Y0 = 0, X1 = 300, Y1 = 200, COLOR = 0x0000FF00, then the trigger at edge N+6.
- Post 3 lines back-to-back. Model LE_ready low for 50 cycles after each trigger. Expect three dispatches in FIFO order, no dispatch while LE_ready = 0, and q_count stepping 3→2→1→0.
- Fill DEPTH = 8 entries with LE_ready = 0, then issue a 9th GO. Expect q_full = 1 and overflow = 1. Release LE_ready; exactly 8 lines are dispatched.
- GO at the same edge as a TRIG pop, with q_count = 4. Expect q_count to stay at 4.
- Assert rst during LOAD idx 2. Expect strobes low next cycle, q_count = 0, idle = 1; no trigger ever issued.
- With LINE_CMD_STATS_EN: 5 completed lines give lines_done = 5. Without it: lines_done stays 0.
